// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared FSM state type and width/bound helpers for mac_neuron (MAC_NEURON_SAT_EN selects saturating narrowing)
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } mac_state_e;

    // Accumulator width: weight width plus index growth plus bias/sign headroom
    function automatic int acc_width(input int n_in, input int ww);
        return ww + $clog2(n_in) + 2;
    endfunction

    // Largest value representable in a signed ww-bit result
    function automatic int sat_hi(input int ww);
        return (1 << (ww - 1)) - 1;
    endfunction

    // Smallest value representable in a signed ww-bit result
    function automatic int sat_lo(input int ww);
        return -(1 << (ww - 1));
    endfunction

endpackage

// File: rtl/mac_neuron_narrow.sv
// rtl/mac_neuron_narrow.sv - reduces the wide accumulator to WW bits; clamps when MAC_NEURON_SAT_EN is defined, wraps otherwise
module mac_neuron_narrow
    import mlp_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int WW    = 4
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic        [WW-1:0]    sum_out
);

`ifdef MAC_NEURON_SAT_EN
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(WW));
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(WW));

    // Clamp the full-precision sum into the signed WW-bit range
    always_comb begin
        if (acc_in > HI) begin
            sum_out = HI[WW-1:0];
        end else if (acc_in < LO) begin
            sum_out = LO[WW-1:0];
        end else begin
            sum_out = acc_in[WW-1:0];
        end
    end
`else
    // Upper accumulator bits are intentionally discarded in wrap mode
    logic unused_hi;
    assign unused_hi = ^acc_in[ACC_W-1:WW];

    // Two's-complement wrap: keep the low WW bits
    always_comb begin
        sum_out = acc_in[WW-1:0];
    end
`endif

endmodule

// File: rtl/mac_neuron.sv
// rtl/mac_neuron.sv - serial multiply-accumulate neuron with binary inputs, bias threshold and step activation (MAC_NEURON_SAT_EN selects sum_out clamping)
module mac_neuron
    import mlp_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int WW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      x,
    input  logic [N_IN*WW-1:0]   w_flat,
    input  logic [WW-1:0]        bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 y,
    output logic [WW-1:0]        sum_out
);

    localparam int ACC_W = acc_width(N_IN, WW);
    // idx must reach N_IN: that extra step is the cycle that registers the result
    localparam int IDX_W = $clog2(N_IN + 1);

    mac_state_e               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_IN-1:0]          x_q, x_d;
    logic [N_IN*WW-1:0]       w_q, w_d;
    logic                     y_q, y_d;
    logic [WW-1:0]            sum_q, sum_d;
    logic                     alive_q, alive_d;

    logic signed [WW-1:0]     w_sel;
    logic                     x_sel;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic [WW-1:0]            sum_narrow;

    // Pick the weight and gate bit addressed by the current index
    always_comb begin
        w_sel = '0;
        x_sel = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_sel = w_q[i*WW +: WW];
                x_sel = x_q[i];
            end
        end
    end

    assign w_ext    = {{(ACC_W-WW){w_sel[WW-1]}}, w_sel};
    assign bias_ext = {{(ACC_W-WW){bias[WW-1]}}, bias};

    mac_neuron_narrow #(
        .ACC_W (ACC_W),
        .WW    (WW)
    ) u_narrow (
        .acc_in  (acc_q),
        .sum_out (sum_narrow)
    );

    // in_ready stays low through reset and only rises after the first edge out of it
    assign in_ready  = alive_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign sum_out   = sum_q;

    // Next-state and datapath: capture operands, accumulate one weight per cycle, then register the result
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        x_d     = x_q;
        w_d     = w_q;
        y_d     = y_q;
        sum_d   = sum_q;
        alive_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (in_ready && in_valid) begin
                    x_d     = x;
                    w_d     = w_flat;
                    acc_d   = -bias_ext;
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (idx_q == IDX_W'(N_IN)) begin
                    // Strictly positive: sign clear and not zero
                    y_d     = !acc_q[ACC_W-1] && (acc_q != '0);
                    sum_d   = sum_narrow;
                    state_d = DONE;
                end else begin
                    if (x_sel) begin
                        acc_d = acc_q + w_ext;
                    end
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                // Returning to IDLE here guarantees a bubble before the next accept
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            y_q     <= 1'b0;
            sum_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            w_q     <= w_d;
            y_q     <= y_d;
            sum_q   <= sum_d;
            alive_q <= alive_d;
        end
    end

endmodule

// File: tb/tb_mac_neuron.sv
// tb/tb_mac_neuron.sv - self-checking bench for mac_neuron (N_IN=4, WW=4; expectations follow MAC_NEURON_SAT_EN)
module tb_mac_neuron;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  x_i;
    logic [15:0] w_i;
    logic [3:0]  bias_i;
    logic        out_valid;
    logic        out_ready;
    logic        y;
    logic [3:0]  sum_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mac_neuron #(.N_IN(4), .WW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x_i),
        .w_flat    (w_i),
        .bias      (bias_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sum_out   (sum_out)
    );

    typedef struct {
        logic [3:0]  x;
        logic [15:0] w;
        logic [3:0]  b;
        logic        ey;
        logic [3:0]  es_sat;
        logic [3:0]  es_wrap;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] pick(input vec_t v);
`ifdef MAC_NEURON_SAT_EN
        return v.es_sat;
`else
        return v.es_wrap;
`endif
    endfunction

    // Reference: plain integer weighted sum minus bias, then activation and narrowing
    function automatic void model(input logic [3:0] xv, input logic [15:0] wv, input logic [3:0] bv,
                                  output logic ey, output logic [3:0] es);
        int s;
        logic signed [3:0] t;
        t = bv;
        s = -int'(t);
        for (int i = 0; i < 4; i++) begin
            if (xv[i]) begin
                t = wv[i*4 +: 4];
                s += int'(t);
            end
        end
        ey = (s > 0);
`ifdef MAC_NEURON_SAT_EN
        if (s > 7) s = 7;
        else if (s < -8) s = -8;
`endif
        es = s[3:0];
    endfunction

    // Called at a negedge with the block idle; returns at a negedge after the result handshake
    task automatic run_op(input string nm, input logic [3:0] xv, input logic [15:0] wv, input logic [3:0] bv,
                          input logic ey, input logic [3:0] es, input int hold);
        int guard;
        int lat;
        x_i = xv; w_i = wv; bias_i = bv; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({nm, "_accept_wait"}, guard, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x_i = 4'($urandom); w_i = 16'($urandom); bias_i = 4'($urandom);
        check({nm, "_busy_ready"}, in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, lat, 5);
        check({nm, "_y"}, y, ey);
        check({nm, "_sum"}, sum_out, es);
        check({nm, "_done_ready"}, in_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            x_i = 4'($urandom); w_i = 16'($urandom); bias_i = 4'($urandom);
            @(negedge clk);
            check({nm, "_hold_valid"}, out_valid, 1'b1);
            check({nm, "_hold_y"}, y, ey);
            check({nm, "_hold_sum"}, sum_out, es);
            check({nm, "_hold_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({nm, "_post_valid"}, out_valid, 1'b0);
        check({nm, "_post_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ey;
        logic [3:0] es;
        logic [3:0] rx;
        logic [15:0] rw;
        logic [3:0] rb;

        tbl[0] = '{4'b0011, 16'h0023, 4'd4, 1'b1, 4'd1, 4'd1};
        tbl[1] = '{4'b0011, 16'h0023, 4'd5, 1'b0, 4'd0, 4'd0};
        tbl[2] = '{4'b1111, 16'h7777, 4'h8, 1'b1, 4'd7, 4'd4};
        tbl[3] = '{4'b1111, 16'h8888, 4'h0, 1'b0, 4'h8, 4'h0};
        tbl[4] = '{4'b0000, 16'h7777, 4'hF, 1'b1, 4'd1, 4'd1};
        tbl[5] = '{4'b0100, 16'h0D00, 4'd2, 1'b0, 4'hB, 4'hB};
        tbl[6] = '{4'b1010, 16'h5060, 4'hE, 1'b1, 4'd7, 4'hD};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x_i = '0; w_i = '0; bias_i = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 1'b0);
        check("rst_sum", sum_out, 4'h0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", in_ready, 1'b0);
        @(negedge clk);
        check("rel_ready_after_edge", in_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].x, tbl[i].w, tbl[i].b, tbl[i].ey, pick(tbl[i]), i % 3);
        end

        // Back-pressure for three cycles with in_valid high, then accept in the cycle right after the handshake
        run_op("bp_first", tbl[0].x, tbl[0].w, tbl[0].b, tbl[0].ey, pick(tbl[0]), 3);
        run_op("bp_next", tbl[3].x, tbl[3].w, tbl[3].b, tbl[3].ey, pick(tbl[3]), 0);
        run_op("bp_prime", tbl[2].x, tbl[2].w, tbl[2].b, tbl[2].ey, pick(tbl[2]), 0);

        // Reset in the middle of accumulation (idx = 2)
        x_i = tbl[0].x; w_i = tbl[0].w; bias_i = tbl[0].b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_y", y, 1'b0);
        check("midrst_sum", sum_out, 4'h0);
        check("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", in_ready, 1'b1);
        check("midrst_valid_after", out_valid, 1'b0);
        run_op("after_rst", tbl[6].x, tbl[6].w, tbl[6].b, tbl[6].ey, pick(tbl[6]), 1);

        for (int r = 0; r < 25; r++) begin
            rx = 4'($urandom);
            rw = 16'($urandom);
            rb = 4'($urandom);
            model(rx, rw, rb, ey, es);
            run_op($sformatf("rnd%0d", r), rx, rw, rb, ey, es, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
